fetch_unit: RTL and testbench

//  Instruction-fetch front end serving the control decoder. Owns the PC, drives the

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: ROM read port, execute redirect/stall controls and
// the instruction stream presented to decode.
interface fetch_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [15:0]       instr_out;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] link_pc;

  modport master (
    output rom_en, rom_addr, instr_out, instr_valid, instr_pc, link_pc,
    input  rom_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  rom_en, rom_addr, instr_out, instr_valid, instr_pc, link_pc,
    output rom_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads a 1-cycle-latency ROM and
// delivers one instruction per cycle, with a 1-entry skid, stall hold and redirect flush.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]       NOP_WORD = 16'h0000
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} state_t;

  state_t            state, state_nxt;
  logic              flush_first;
  logic              issue;

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;

  logic              skid_valid;
  logic [15:0]       skid_word;
  logic [ADDR_W-1:0] skid_pc;

  logic [15:0]       instr_q;
  logic              valid_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [ADDR_W-1:0] link_pc_q;

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;

    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (bus.stall) state_nxt = HOLD;
      HOLD:    if (!bus.stall) state_nxt = RUN;
      FLUSH:   if (!flush_first) state_nxt = bus.stall ? HOLD : RUN;
      default: state_nxt = BOOT;
    endcase
    if (bus.redirect) state_nxt = FLUSH;

    // The redirect target is always fetched in the first flush cycle, even under
    // stall, so it can park in the skid and be presented as soon as stall drops.
    if (!bus.redirect && state != BOOT)
      issue = !bus.stall || (state == FLUSH && flush_first);
  end

  assign bus.rom_en      = issue;
  assign bus.rom_addr    = pc;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.link_pc     = link_pc_q;

  // NOTE: state registers use non-blocking assignments only, so every process
  // sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT;
      flush_first <= 1'b0;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_word   <= NOP_WORD;
      skid_pc     <= '0;
      instr_q     <= NOP_WORD;
      valid_q     <= 1'b0;
      instr_pc_q  <= '0;
      link_pc_q   <= ADDR_W'(1);
    end else begin
      state       <= state_nxt;
      flush_first <= bus.redirect;
      inflight    <= issue;
      inflight_pc <= pc;

      if (bus.redirect)
        pc <= bus.redirect_pc;
      else if (issue)
        pc <= pc + ADDR_W'(1);

      // Issue stops while stalled, so at most one word can be in flight when
      // stall rises; that word lands in the skid and nothing else can arrive.
      if (bus.redirect) begin
        skid_valid <= 1'b0;
        instr_q    <= NOP_WORD;
        valid_q    <= 1'b0;
      end else if (bus.stall) begin
        if (inflight) begin
          skid_valid <= 1'b1;
          skid_word  <= bus.rom_data;
          skid_pc    <= inflight_pc;
        end
      end else if (skid_valid) begin
        skid_valid <= 1'b0;
        instr_q    <= skid_word;
        valid_q    <= 1'b1;
        instr_pc_q <= skid_pc;
        link_pc_q  <= skid_pc + ADDR_W'(1);
      end else if (inflight) begin
        instr_q    <= bus.rom_data;
        valid_q    <= 1'b1;
        instr_pc_q <= inflight_pc;
        link_pc_q  <= inflight_pc + ADDR_W'(1);
      end else begin
        instr_q <= NOP_WORD;
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 0xFFE) fed by a
// behavioural ROM whose word at address a is {4'h1, a}; outputs sampled on negedge.
module tb_fetch_unit;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_if #(.ADDR_W(ADDR_W)) b0 ();
  fetch_if #(.ADDR_W(ADDR_W)) b1 ();

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(12'h000), .NOP_WORD(16'h0000)) u0 (
    .clk(clk), .rst(rst), .bus(b0.master));
  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(12'hFFE), .NOP_WORD(16'h0000)) u1 (
    .clk(clk), .rst(rst), .bus(b1.master));

  always #5 clk = ~clk;

  always @(posedge clk) if (b0.rom_en) b0.rom_data <= {4'h1, b0.rom_addr};
  always @(posedge clk) if (b1.rom_en) b1.rom_data <= {4'h1, b1.rom_addr};

  task automatic test_reset();
    logic [40:0] got, exp;
    rst = 1'b0;
    b0.stall = 1'b0; b0.redirect = 1'b0; b0.redirect_pc = '0;
    b1.stall = 1'b0; b1.redirect = 1'b0; b1.redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    got = {b0.instr_valid, b0.instr_out, b0.instr_pc, b0.link_pc};
    exp = {1'b0, 16'h0000, 12'h000, 12'h001};
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", got, exp); end
    n_cmp++;
    if ({b0.rom_en, b0.rom_addr} !== {1'b0, 12'h000}) begin
      n_bad++; $display("FAIL reset_rom: got %b/%h want 0/000", b0.rom_en, b0.rom_addr);
    end
    n_cmp++;
    if ({b1.rom_en, b1.rom_addr, b1.link_pc} !== {1'b0, 12'hFFE, 12'h001}) begin
      n_bad++; $display("FAIL reset_rom_u1: got %b/%h/%h want 0/ffe/001", b1.rom_en, b1.rom_addr, b1.link_pc);
    end
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    logic [40:0] got, exp;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({b0.rom_en, b0.rom_addr} !== {1'b1, 12'h000}) begin
          n_bad++; $display("FAIL boot_issue: got %b/%h want 1/000", b0.rom_en, b0.rom_addr);
        end
      end
      if (c < 3) begin
        n_cmp++;
        if ({b0.instr_valid, b0.instr_out} !== 17'h0) begin
          n_bad++; $display("FAIL stream_bubble c%0d: got %b/%h want 0/0000", c, b0.instr_valid, b0.instr_out);
        end
      end else begin
        got = {b0.instr_valid, b0.instr_out, b0.instr_pc, b0.link_pc};
        exp = {1'b1, 16'h1000 + 16'(c - 3), 12'(c - 3), 12'(c - 2)};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL stream c%0d: got %h want %h", c, got, exp); end
      end
    end
  endtask

  // Entered with instr_pc=4 displayed.
  task automatic test_stall();
    logic [40:0] got, exp;
    b0.stall = 1'b1;
    #1;
    n_cmp++;
    if (b0.rom_en !== 1'b0) begin n_bad++; $display("FAIL stall_rom_en: got %b want 0", b0.rom_en); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = {b0.instr_valid, b0.instr_out, b0.instr_pc, b0.link_pc};
      exp = {1'b1, 16'h1004, 12'h004, 12'h005};
      n_cmp++;
      if (got !== exp || b0.rom_en !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold %0d: got %h en %b want %h en 0", k, got, b0.rom_en, exp);
      end
    end
    b0.stall = 1'b0;
    #1;
    n_cmp++;
    if ({b0.rom_en, b0.rom_addr} !== {1'b1, 12'h006}) begin
      n_bad++; $display("FAIL stall_resume_rom: got %b/%h want 1/006", b0.rom_en, b0.rom_addr);
    end
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      got = {b0.instr_valid, b0.instr_out, b0.instr_pc, b0.link_pc};
      exp = {1'b1, 16'h1000 + 16'(k), 12'(k), 12'(k + 1)};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL stall_release %0d: got %h want %h", k, got, exp); end
    end
  endtask

  task automatic test_redirect();
    logic [40:0] got, exp;
    b0.redirect = 1'b1; b0.redirect_pc = 12'h020;
    @(negedge clk);
    b0.redirect = 1'b0;
    #1;
    n_cmp++;
    if ({b0.rom_en, b0.rom_addr, b0.instr_valid, b0.instr_out} !== {1'b1, 12'h020, 1'b0, 16'h0000}) begin
      n_bad++; $display("FAIL redir_n1: got en %b addr %h v %b i %h want 1/020/0/0000",
                        b0.rom_en, b0.rom_addr, b0.instr_valid, b0.instr_out);
    end
    @(negedge clk);
    n_cmp++;
    if ({b0.instr_valid, b0.instr_out} !== 17'h0) begin
      n_bad++; $display("FAIL redir_n2: got %b/%h want 0/0000", b0.instr_valid, b0.instr_out);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      got = {b0.instr_valid, b0.instr_out, b0.instr_pc, b0.link_pc};
      exp = {1'b1, 16'h1020 + 16'(k), 12'h020 + 12'(k), 12'h021 + 12'(k)};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL redir_target %0d: got %h want %h", k, got, exp); end
    end
  endtask

  task automatic test_redirect_stall();
    logic [40:0] got, exp;
    b0.redirect = 1'b1; b0.redirect_pc = 12'h040; b0.stall = 1'b1;
    @(negedge clk);
    b0.redirect = 1'b0;
    #1;
    n_cmp++;
    if ({b0.rom_en, b0.rom_addr, b0.instr_valid, b0.instr_out} !== {1'b1, 12'h040, 1'b0, 16'h0000}) begin
      n_bad++; $display("FAIL rs_flush: got en %b addr %h v %b i %h want 1/040/0/0000",
                        b0.rom_en, b0.rom_addr, b0.instr_valid, b0.instr_out);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({b0.rom_en, b0.instr_valid, b0.instr_out} !== 18'h0) begin
        n_bad++; $display("FAIL rs_wait %0d: got en %b v %b i %h want 0/0/0000",
                          k, b0.rom_en, b0.instr_valid, b0.instr_out);
      end
    end
    b0.stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = {b0.instr_valid, b0.instr_out, b0.instr_pc, b0.link_pc};
      exp = {1'b1, 16'h1040 + 16'(k), 12'h040 + 12'(k), 12'h041 + 12'(k)};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL rs_release %0d: got %h want %h", k, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [40:0] got, exp;
    b0.redirect = 1'b1; b0.redirect_pc = 12'h100;
    @(negedge clk);
    b0.redirect_pc = 12'h200;
    @(negedge clk);
    b0.redirect = 1'b0;
    #1;
    n_cmp++;
    if ({b0.rom_en, b0.rom_addr, b0.instr_valid} !== {1'b1, 12'h200, 1'b0}) begin
      n_bad++; $display("FAIL b2b_issue: got en %b addr %h v %b want 1/200/0", b0.rom_en, b0.rom_addr, b0.instr_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({b0.instr_valid, b0.instr_out} !== 17'h0) begin
      n_bad++; $display("FAIL b2b_bubble: got %b/%h want 0/0000", b0.instr_valid, b0.instr_out);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      got = {b0.instr_valid, b0.instr_out, b0.instr_pc, b0.link_pc};
      exp = {1'b1, 16'h1200 + 16'(k), 12'h200 + 12'(k), 12'h201 + 12'(k)};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL b2b_target %0d: got %h want %h", k, got, exp); end
    end
  endtask

  // Entered streaming with 0x1201 displayed and 0x202 in flight.
  task automatic test_reset_mid_stream();
    logic [40:0] got, exp;
    b0.stall = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({b0.instr_valid, b0.instr_out} !== {1'b1, 16'h1201}) begin
      n_bad++; $display("FAIL mid_hold: got %b/%h want 1/1201", b0.instr_valid, b0.instr_out);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; b0.stall = 1'b0;
    #1;
    n_cmp++;
    if ({b0.rom_en, b0.rom_addr, b0.instr_valid, b0.instr_out} !== {1'b0, 12'h000, 1'b0, 16'h0000}) begin
      n_bad++; $display("FAIL mid_reset: got en %b addr %h v %b i %h want 0/000/0/0000",
                        b0.rom_en, b0.rom_addr, b0.instr_valid, b0.instr_out);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 3) begin
        n_cmp++;
        if ({b0.instr_valid, b0.instr_out} !== 17'h0) begin
          n_bad++; $display("FAIL mid_bubble c%0d: got %b/%h want 0/0000", c, b0.instr_valid, b0.instr_out);
        end
      end else begin
        got = {b0.instr_valid, b0.instr_out, b0.instr_pc, b0.link_pc};
        exp = {1'b1, 16'h1000 + 16'(c - 3), 12'(c - 3), 12'(c - 2)};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL mid_restart c%0d: got %h want %h", c, got, exp); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [40:0] got;
    logic [40:0] exp_tab [3:6];
    exp_tab[3] = {1'b1, 16'h1FFE, 12'hFFE, 12'hFFF};
    exp_tab[4] = {1'b1, 16'h1FFF, 12'hFFF, 12'h000};
    exp_tab[5] = {1'b1, 16'h1000, 12'h000, 12'h001};
    exp_tab[6] = {1'b1, 16'h1001, 12'h001, 12'h002};
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({b1.rom_en, b1.rom_addr} !== {1'b1, 12'hFFE}) begin
          n_bad++; $display("FAIL wrap_boot: got %b/%h want 1/ffe", b1.rom_en, b1.rom_addr);
        end
      end
      if (c >= 3) begin
        got = {b1.instr_valid, b1.instr_out, b1.instr_pc, b1.link_pc};
        n_cmp++;
        if (got !== exp_tab[c]) begin n_bad++; $display("FAIL wrap c%0d: got %h want %h", c, got, exp_tab[c]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_reset_mid_stream();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
